// File: rtl/prog_loader.sv
// Boot-time program loader: takes a length-prefixed byte stream from the UART
// receiver, assembles little-endian 32-bit words, writes them into instruction
// memory, acknowledges the host, and then releases the core from reset.
//
// Handshakes: rx_valid is a one-cycle strobe with no back-pressure, so a byte
// is consumed on every cycle that rx_valid is high. tx_valid is held high with
// tx_data stable until the cycle tx_valid && tx_ready is seen. That cycle
// completes the transfer, and tx_valid drops on the following cycle.
module prog_loader #(
  parameter int          IMEM_DEPTH = 32,
  parameter int          ADDR_W     = 5,
  parameter logic [7:0]  ACK_BYTE   = 8'hAA,
  parameter logic [7:0]  ERR_BYTE   = 8'hEE
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rstn,
  output logic              busy,
  output logic              err,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ACK  = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t state, state_n;

  // The word counters are one bit wider than the address so that a full
  // memory load (N = IMEM_DEPTH) can be represented.
  logic [ADDR_W:0]   n_words, n_words_n;
  logic [ADDR_W:0]   word_idx, word_idx_n;
  logic [ADDR_W:0]   idx_inc;
  logic [1:0]        byte_cnt, byte_cnt_n;
  logic [31:0]       word_buf, word_buf_n;
  logic [31:0]       word_next;

  logic [7:0]        tx_data_n;
  logic              tx_valid_n;
  logic              imem_we_n;
  logic [ADDR_W-1:0] imem_addr_n;
  logic [31:0]       imem_wdata_n;
  logic              core_rstn_n;
  logic              busy_n;
  logic              err_n;

  logic              handshake;
  logic              hdr_ok;

  assign state_dbg = state;
  assign handshake = tx_valid && tx_ready;
  assign hdr_ok    = (rx_data != 8'd0) && (32'(rx_data) <= IMEM_DEPTH);
  assign idx_inc   = word_idx + {{ADDR_W{1'b0}}, 1'b1};
  // Incoming bytes enter at the top, so after four bytes the first one has
  // moved down to bits [7:0], which gives the little-endian ordering.
  assign word_next = {rx_data, word_buf[31:8]};

  // State and all registered outputs update together; reset is asynchronous.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      n_words    <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      word_buf   <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rstn  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      n_words    <= n_words_n;
      word_idx   <= word_idx_n;
      byte_cnt   <= byte_cnt_n;
      word_buf   <= word_buf_n;
      tx_data    <= tx_data_n;
      tx_valid   <= tx_valid_n;
      imem_we    <= imem_we_n;
      imem_addr  <= imem_addr_n;
      imem_wdata <= imem_wdata_n;
      core_rstn  <= core_rstn_n;
      busy       <= busy_n;
      err        <= err_n;
    end
  end

  // Next-state and next-output logic. Everything holds by default, and the write strobe is a single-cycle pulse.
  always_comb begin
    state_n      = state;
    n_words_n    = n_words;
    word_idx_n   = word_idx;
    byte_cnt_n   = byte_cnt;
    word_buf_n   = word_buf;
    tx_data_n    = tx_data;
    tx_valid_n   = tx_valid;
    imem_we_n    = 1'b0;
    imem_addr_n  = imem_addr;
    imem_wdata_n = imem_wdata;
    core_rstn_n  = core_rstn;
    busy_n       = busy;
    err_n        = err;

    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          busy_n = 1'b1;
          if (hdr_ok) begin
            n_words_n  = rx_data[ADDR_W:0];
            word_idx_n = '0;
            byte_cnt_n = '0;
            state_n    = S_LOAD;
          end else begin
            err_n      = 1'b1;
            tx_valid_n = 1'b1;
            tx_data_n  = ERR_BYTE;
            state_n    = S_ERR;
          end
        end
      end

      S_LOAD: begin
        if (rx_valid) begin
          word_buf_n = word_next;
          byte_cnt_n = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            imem_we_n    = 1'b1;
            imem_addr_n  = word_idx[ADDR_W-1:0];
            imem_wdata_n = word_next;
            word_idx_n   = idx_inc;
            if (idx_inc == n_words) begin
              state_n = S_ACK;
            end
          end
        end
      end

      // The first ACK cycle carries the final write. tx_valid is raised one cycle later.
      S_ACK: begin
        tx_data_n = ACK_BYTE;
        if (handshake) begin
          tx_valid_n  = 1'b0;
          busy_n      = 1'b0;
          core_rstn_n = 1'b1;
          state_n     = S_RUN;
        end else begin
          tx_valid_n = 1'b1;
        end
      end

      S_RUN: begin
        state_n = S_RUN;
      end

      S_ERR: begin
        if (handshake) begin
          tx_valid_n = 1'b0;
          busy_n     = 1'b0;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a byte-queue reference model predicts every output
// each cycle, and literal checks pin known words and handshake bytes.
module tb_prog_loader;

  logic        clk;
  logic        rstn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        imem_we;
  logic [4:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rstn;
  logic        busy;
  logic        err;
  logic [2:0]  state_dbg;

  int vectors;
  int miscompares;

  prog_loader dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rstn  (core_rstn),
    .busy       (busy),
    .err        (err),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_LOAD = 1, M_ACKP = 2, M_ACK = 3, M_RUN = 4, M_ERR = 5;

  int          mode;
  int          m_n;
  int          words;
  logic [7:0]  bq[$];
  logic        hs;
  logic        e_we, e_txv, e_core, e_busy, e_err;
  logic [4:0]  e_addr;
  logic [31:0] e_wdata;
  logic [7:0]  e_txd;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode = M_IDLE; m_n = 0; words = 0; bq.delete();
      e_we = 0; e_txv = 0; e_core = 0; e_busy = 0; e_err = 0;
      e_addr = 0; e_wdata = 0; e_txd = 0;
    end else begin
      hs = e_txv && tx_ready;
      e_we = 0;
      case (mode)
        M_IDLE: if (rx_valid) begin
          e_busy = 1;
          if (rx_data >= 8'd1 && rx_data <= 8'd32) begin
            mode = M_LOAD; m_n = int'(rx_data); words = 0; bq.delete();
          end else begin
            mode = M_ERR; e_err = 1; e_txv = 1; e_txd = 8'hEE;
          end
        end
        M_LOAD: if (rx_valid) begin
          bq.push_back(rx_data);
          if (bq.size() == 4) begin
            e_we = 1;
            e_addr = words[4:0];
            e_wdata = {bq[3], bq[2], bq[1], bq[0]};
            bq.delete();
            words++;
            if (words == m_n) mode = M_ACKP;
          end
        end
        M_ACKP: begin e_txv = 1; e_txd = 8'hAA; mode = M_ACK; end
        M_ACK: if (hs) begin e_txv = 0; e_busy = 0; e_core = 1; mode = M_RUN; end
        M_ERR: if (hs) begin e_txv = 0; e_busy = 0; end
        default: ;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] wr_data_log[$];
  logic [4:0]  wr_addr_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    check("ctrl", {59'd0, imem_we, core_rstn, busy, err, tx_valid},
                  {59'd0, e_we, e_core, e_busy, e_err, e_txv});
    if (e_we) check("write", {27'd0, imem_addr, imem_wdata}, {27'd0, e_addr, e_wdata});
    if (e_txv) check("tx_data", {56'd0, tx_data}, {56'd0, e_txd});
    if (imem_we) begin
      wr_addr_log.push_back(imem_addr);
      wr_data_log.push_back(imem_wdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs();
    check("rst_outputs",
          {14'd0, tx_data, tx_valid, imem_we, imem_addr, imem_wdata, core_rstn, busy, err},
          64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    #1 check_reset_outputs();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    rx_data = $urandom_range(0, 255);
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for tx_valid, hold tx_ready low for `hold` cycles, then handshake.
  task automatic tx_exchange(input int hold, output logic [7:0] got, output bit seen);
    seen = 0;
    got = 8'h00;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_valid) begin seen = 1; break; end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL tx_timeout: got tx_valid=0 expected 1 within 300 cycles");
    end else begin
      got = tx_data;
      repeat (hold) @(negedge clk);
      @(posedge clk);
      #1 tx_ready = 1'b1;
      @(posedge clk);
      #1 tx_ready = 1'b0;
    end
  endtask

  // ---------------- test sequence ----------------
  logic [7:0] got;
  bit         seen;
  int         nlog;
  logic [7:0] prog1[8];

  initial begin
    vectors = 0; miscompares = 0;
    rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    prog1 = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
    #1 check_reset_outputs();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Two-word program with random byte spacing.
    send_byte(8'h02);
    foreach (prog1[i]) begin
      send_byte(prog1[i]);
      gap($urandom_range(0, 3));
    end
    exp_q = '{32'h00100013, 32'h00200093};
    tx_exchange(3, got, seen);
    check("ack_byte", {56'd0, got}, {56'd0, 8'hAA});
    @(negedge clk);
    check("core_rstn_after_ack", {63'd0, core_rstn}, 64'd1);
    check("n_writes_2", wr_data_log.size(), 2);
    for (int i = 0; i < 2; i++) begin
      if (i < wr_data_log.size()) begin
        check("prog1_word", {27'd0, wr_addr_log[i], wr_data_log[i]}, {27'd0, 5'(i), exp_q[i]});
      end
    end

    // In RUN: random bytes are ignored.
    nlog = wr_data_log.size();
    for (int i = 0; i < 20; i++) begin
      send_byte($urandom_range(0, 255));
      gap($urandom_range(0, 2));
    end
    check("run_no_writes", wr_data_log.size(), nlog);
    check("run_core_rstn", {63'd0, core_rstn}, 64'd1);

    // Full 32-word load, back-to-back bytes, ACK held off for 50 cycles.
    do_reset();
    wr_addr_log.delete(); wr_data_log.delete();
    send_byte(8'h20);
    for (int i = 0; i < 128; i++) send_byte($urandom_range(0, 255));
    tx_exchange(50, got, seen);
    check("ack_byte_full", {56'd0, got}, {56'd0, 8'hAA});
    check("n_writes_32", wr_data_log.size(), 32);
    for (int i = 0; i < 32; i++) begin
      if (i < wr_addr_log.size()) check("full_addr", {59'd0, wr_addr_log[i]}, i);
    end

    // Rejected headers: 0 and 33.
    for (int k = 0; k < 2; k++) begin
      do_reset();
      nlog = wr_data_log.size();
      send_byte(k == 0 ? 8'h00 : 8'h21);
      tx_exchange($urandom_range(0, 5), got, seen);
      check("err_byte", {56'd0, got}, {56'd0, 8'hEE});
      for (int i = 0; i < 8; i++) send_byte($urandom_range(0, 255));
      @(negedge clk);
      check("err_sticky", {62'd0, err, core_rstn}, {62'd0, 1'b1, 1'b0});
      check("err_no_writes", wr_data_log.size(), nlog);
    end

    // Reset mid-load: header 3, six bytes, then async reset.
    do_reset();
    nlog = wr_data_log.size();
    send_byte(8'h03);
    for (int i = 0; i < 6; i++) send_byte(8'h40 + 8'(i));
    gap(1);
    do_reset();
    gap(2);
    check("partial_not_written", wr_data_log.size(), nlog + 1);
    send_byte(8'h01);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    tx_exchange(0, got, seen);
    check("reload_ack", {56'd0, got}, {56'd0, 8'hAA});
    check("reload_count", wr_data_log.size(), nlog + 2);
    if (wr_data_log.size() == nlog + 2) begin
      check("reload_word", {27'd0, wr_addr_log[nlog + 1], wr_data_log[nlog + 1]},
            {27'd0, 5'd0, 32'h00100013});
    end
    gap(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
